rs_issue_select: RTL and testbench
==================================

// Module: rs_issue_select
// PURPOSE
//  Issue stage directly downstream of a reservation station. Picks one ready RS entry per issue
//  (round-robin), pulses finish/finish_index back to free the slot, hands the operands to one
//  multi-cycle functional unit over a valid/ready handshake, then broadcasts the result on the
//  CDB through a request/grant arbiter. One entry is in flight at a time.
// PARAMETERS
//  size      4                      RS entries watched; must equal the paired station's size
//  IDX_W     $clog2(size)           width of finish_index / round-robin pointer
// PORTS
//  clk            in   1             clock; all state updates on posedge
//  reset          in   1             synchronous, active-high reset
//  flush          in   1             squash: drop any in-flight op, no finish, no broadcast
//  rs_data        in   lc3b_rs_entry[size]  RS contents (op, vj, vk, dest, pc, busy)
//  rs_ready       in   size          per-entry rj&&rk from the RS
//  finish         out  1             one-cycle pulse: selected entry leaves the RS
//  finish_index   out  IDX_W         index being freed (valid when finish=1)
//  fu_valid       out  1             operands presented to FU
//  fu_ready       in   1             FU accepts (handshake completes when valid&&ready)
//  fu_op          out  4             latched op
//  fu_a, fu_b     out  lc3b_word     latched vj, vk
//  fu_pc          out  lc3b_word     latched pc
//  fu_done        in   1             FU result valid (one-cycle pulse)
//  fu_result      in   lc3b_word     FU result
//  cdb_req        out  1             request CDB
//  cdb_grant      in   1             CDB granted this cycle (combinational from arbiter)
//  cdb_out        out  lc3b_cdb      {dest, value, ready} driven onto CDB
//  busy           out  1             state != IDLE
// BEHAVIOUR
//  Reset/flush: state=IDLE, rr_ptr=0, finish=0, fu_valid=0, cdb_req=0, cdb_out='0, busy=0.
//   flush takes priority over every other event in the same cycle (incl. grant, fu_done).
//  Eligible entry z: rs_ready[z] && rs_data[z].busy. Select = first eligible scanning
//   rr_ptr, rr_ptr+1, ... wrapping mod size.
//  FSM:
//   IDLE  : if any eligible and !flush -> finish=1, finish_index=sel (combinational this
//           cycle); latch op/vj/vk/pc/dest of sel; rr_ptr<=(sel+1)%size; next ISSUE.
//           No eligible -> stay, finish=0.
//   ISSUE : fu_valid=1, fu_* from latches, held stable until fu_ready; on fu_valid&&fu_ready
//           -> EXEC.
//   EXEC  : wait for fu_done; capture fu_result into value reg -> BCAST. fu_done in any
//           other state is ignored.
//   BCAST : cdb_req=1; cdb_out.dest/value from regs; cdb_out.ready=cdb_grant.
//           On cdb_grant -> IDLE (next select may occur the following cycle).
//  finish is only asserted in IDLE, never twice for one entry; the RS clears busy on the
//   next edge so the same index is not reselected.
//  Minimum latency select->broadcast: 3 cycles (fu_ready=1 at ISSUE, fu_done one cycle later,
//   grant immediately). cdb_out.ready=0 whenever not (BCAST && cdb_grant).
//  Wrap: rr_ptr=size-1 and sel=size-1 -> rr_ptr=0.
//  Reset or flush mid-operation (any state) abandons the op; no later finish/CDB for it.
// TESTING
//  1 reset; rs_ready=4'b0100 busy[2]=1 -> finish=1 idx=2 same cycle; fu_valid next cycle.
//  2 rs_ready=4'b1111 all busy, rr_ptr=0, ops complete back to back -> issue order 0,1,2,3,0.
//  3 fu_ready held 0 for 5 cycles -> fu_valid/fu_a/fu_b stable; no 2nd finish pulse.
//  4 op dest=5, fu_result=16'h1234, grant delayed 3 cycles -> cdb_req high 4 cycles;
//    cdb_out={5,16'h1234,1} only in grant cycle.
//  5 flush asserted same cycle as cdb_grant in BCAST -> cdb_out.ready=0, state=IDLE, busy=0.
//  6 reset asserted in EXEC, then fu_done pulse -> ignored; no cdb_req, rr_ptr=0.

Source files
------------

// File: rtl/rs_issue_select.sv
// rs_issue_select: issue stage behind a reservation station.
// Picks one ready entry round-robin, frees its RS slot with a one-cycle
// finish pulse, hands the operands to a multi-cycle functional unit, then
// broadcasts the result on the CDB once the arbiter grants it. Only one
// entry is in flight at a time.
//
// rs_data packs size entries of 56 bits each, entry z at [z*56 +: 56]:
//   [55:52] op   [51:36] vj   [35:20] vk   [19:17] dest   [16:1] pc   [0] busy
// cdb_out layout: [19:17] dest   [16:1] value   [0] ready
//
// Handshakes: fu_valid/fu_ready is strict valid/ready -- once fu_valid rises,
// fu_op/fu_a/fu_b/fu_pc hold steady until the cycle fu_valid && fu_ready,
// which is the transfer. The only exception is reset/flush, which withdraws
// fu_valid without a transfer. cdb_req stays high until cdb_grant; the
// result counts as broadcast only in the cycle cdb_out.ready (= grant) is 1.
module rs_issue_select #(
  parameter int size  = 4,
  parameter int IDX_W = $clog2(size)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [size*56-1:0]   rs_data,
  input  logic [size-1:0]      rs_ready,
  output logic                 finish,
  output logic [IDX_W-1:0]     finish_index,
  output logic                 fu_valid,
  input  logic                 fu_ready,
  output logic [3:0]           fu_op,
  output logic [15:0]          fu_a,
  output logic [15:0]          fu_b,
  output logic [15:0]          fu_pc,
  input  logic                 fu_done,
  input  logic [15:0]          fu_result,
  output logic                 cdb_req,
  input  logic                 cdb_grant,
  output logic [19:0]          cdb_out,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2,
    BCAST = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] sel_next;
  logic             found;
  logic             load;
  logic             capture;
  logic             quiet;
  logic [size-1:0]  elig;
  logic [55:0]      ent [size];
  logic [55:0]      sel_ent;

  logic [3:0]  op_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] pc_q;
  logic [2:0]  dest_q;
  logic [15:0] value_q;

  // reset and flush both silence every output in the cycle they are seen
  assign quiet = reset | flush;

  // unpack entries and mark the ones that are both operand-ready and occupied
  always_comb begin
    elig = '0;
    for (int i = 0; i < size; i++) begin
      ent[i]  = rs_data[i*56 +: 56];
      elig[i] = rs_ready[i] & ent[i][0];
    end
  end

  // round-robin pick: first eligible entry starting at rr_ptr, wrapping
  always_comb begin
    int j;
    found = 1'b0;
    sel   = '0;
    j     = 0;
    for (int i = 0; i < size; i++) begin
      j = (int'(rr_ptr) + i) % size;
      if (!found && elig[j[IDX_W-1:0]]) begin
        found = 1'b1;
        sel   = j[IDX_W-1:0];
      end
    end
  end

  assign sel_ent  = ent[sel];
  assign sel_next = (sel == IDX_W'(size - 1)) ? '0 : sel + 1'b1;

  // next-state and handshake outputs; flush/reset override every other event
  always_comb begin
    state_n  = state;
    load     = 1'b0;
    capture  = 1'b0;
    finish   = 1'b0;
    fu_valid = 1'b0;
    cdb_req  = 1'b0;
    cdb_out  = '0;
    if (quiet) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            finish  = 1'b1;
            load    = 1'b1;
            state_n = ISSUE;
          end
        end
        ISSUE: begin
          fu_valid = 1'b1;
          if (fu_ready) state_n = EXEC;
        end
        EXEC: begin
          if (fu_done) begin
            capture = 1'b1;
            state_n = BCAST;
          end
        end
        BCAST: begin
          cdb_req = 1'b1;
          cdb_out = {dest_q, value_q, cdb_grant};
          if (cdb_grant) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign finish_index = sel;
  assign fu_op        = op_q;
  assign fu_a         = a_q;
  assign fu_b         = b_q;
  assign fu_pc        = pc_q;
  assign busy         = !quiet && (state != IDLE);
  assign dbg_state    = state;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // round-robin pointer moves past the entry just selected
  always_ff @(posedge clk) begin
    if (quiet)     rr_ptr <= '0;
    else if (load) rr_ptr <= sel_next;
  end

  // operand and result holding registers for the single in-flight entry
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      pc_q    <= '0;
      dest_q  <= '0;
      value_q <= '0;
    end else begin
      if (load) begin
        op_q   <= sel_ent[55:52];
        a_q    <= sel_ent[51:36];
        b_q    <= sel_ent[35:20];
        dest_q <= sel_ent[19:17];
        pc_q   <= sel_ent[16:1];
      end
      if (capture) value_q <= fu_result;
    end
  end

endmodule

// File: tb/tb_rs_issue_select.sv
// Bench for rs_issue_select: directed scenarios, an emulated RS that clears
// busy after each finish pulse, a transaction-level reference model checked
// every cycle, and literal expectations for the documented scenarios.
module tb_rs_issue_select;

  logic          clk;
  logic          reset;
  logic          flush;
  logic [223:0]  rs_data;
  logic [3:0]    rs_ready;
  logic          finish;
  logic [1:0]    finish_index;
  logic          fu_valid;
  logic          fu_ready;
  logic [3:0]    fu_op;
  logic [15:0]   fu_a;
  logic [15:0]   fu_b;
  logic [15:0]   fu_pc;
  logic          fu_done;
  logic [15:0]   fu_result;
  logic          cdb_req;
  logic          cdb_grant;
  logic [19:0]   cdb_out;
  logic          busy;
  logic [1:0]    dbg_state;

  rs_issue_select #(.size(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .rs_data(rs_data), .rs_ready(rs_ready),
    .finish(finish), .finish_index(finish_index),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_op(fu_op), .fu_a(fu_a), .fu_b(fu_b), .fu_pc(fu_pc),
    .fu_done(fu_done), .fu_result(fu_result),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_out(cdb_out),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- emulated reservation station ----------------
  logic [3:0]  e_op   [4];
  logic [15:0] e_a    [4];
  logic [15:0] e_b    [4];
  logic [2:0]  e_dest [4];
  logic [15:0] e_pc   [4];
  logic        e_busy [4];
  logic        e_ready[4];

  always_comb begin
    rs_data  = '0;
    rs_ready = '0;
    for (int i = 0; i < 4; i++) begin
      rs_data[i*56 +: 56] = {e_op[i], e_a[i], e_b[i], e_dest[i], e_pc[i], e_busy[i]};
      rs_ready[i]         = e_ready[i];
    end
  end

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  bit model_on = 1'b0;
  logic [1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One in-flight transaction described by three milestones: selected,
  // handed to the FU, result received. The pointer names the first slot to
  // consider on the next pick.
  int          m_rr = 0;
  bit          m_have = 0, m_handed = 0, m_res = 0;
  logic [3:0]  m_op;
  logic [15:0] m_a, m_b, m_pc, m_val;
  logic [2:0]  m_dest;

  always @(negedge clk) begin : model_cmp
    bit   quiet;
    bit   found;
    int   sel;
    int   j;
    bit   x_fin, x_fv, x_req, x_busy;
    logic [19:0] x_cdb;
    if (model_on) begin
      quiet = reset || flush;
      found = 0;
      sel   = 0;
      for (int k = 0; k < 4; k++) begin
        j = (m_rr + k) % 4;
        if (!found && e_ready[j] && e_busy[j]) begin
          found = 1;
          sel   = j;
        end
      end
      x_fin  = !quiet && !m_have && found;
      x_fv   = !quiet && m_have && !m_handed;
      x_req  = !quiet && m_have && m_res;
      x_busy = !quiet && m_have;
      x_cdb  = x_req ? {m_dest, m_val, cdb_grant} : 20'h0;

      chk("m_finish", finish, x_fin);
      if (x_fin) chk("m_finish_index", finish_index, sel);
      chk("m_fu_valid", fu_valid, x_fv);
      if (x_fv) begin
        chk("m_fu_op", fu_op, m_op);
        chk("m_fu_a", fu_a, m_a);
        chk("m_fu_b", fu_b, m_b);
        chk("m_fu_pc", fu_pc, m_pc);
      end
      chk("m_cdb_req", cdb_req, x_req);
      chk("m_cdb_out", cdb_out, x_cdb);
      chk("m_busy", busy, x_busy);

      if (quiet) begin
        m_have = 0; m_handed = 0; m_res = 0; m_rr = 0;
      end else if (!m_have) begin
        if (found) begin
          m_have = 1;
          m_op = e_op[sel]; m_a = e_a[sel]; m_b = e_b[sel];
          m_pc = e_pc[sel]; m_dest = e_dest[sel];
          m_rr = (sel + 1) % 4;
        end
      end else if (!m_handed) begin
        if (fu_ready) m_handed = 1;
      end else if (!m_res) begin
        if (fu_done) begin
          m_res = 1;
          m_val = fu_result;
        end
      end else if (cdb_grant) begin
        m_have = 0; m_handed = 0; m_res = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // one full cycle; the RS frees the slot announced by finish on the edge
  task automatic tick();
    logic       f;
    logic [1:0] fi;
    @(negedge clk);
    f  = finish;
    fi = finish_index;
    @(posedge clk);
    #1;
    if (f) e_busy[fi] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0;
    fu_ready = 1'b0; fu_done = 1'b0; cdb_grant = 1'b0; fu_result = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_rs();
    for (int i = 0; i < 4; i++) begin
      e_op[i]    = 4'(i + 1);
      e_a[i]     = 16'h1000 + 16'(i);
      e_b[i]     = 16'h2000 + 16'(i);
      e_dest[i]  = 3'(i + 1);
      e_pc[i]    = 16'h3000 + 16'(i * 2);
      e_busy[i]  = 1'b0;
      e_ready[i] = 1'b0;
    end
  endtask

  task automatic make_eligible(input int idx);
    e_ready[idx] = 1'b1;
    e_busy[idx]  = 1'b1;
  endtask

  // called at the start of the ISSUE cycle; returns at the start of IDLE
  task automatic complete_op(input int rdy_wait, input int done_wait,
                             input int grant_wait, input logic [15:0] res);
    fu_ready = 1'b0;
    repeat (rdy_wait) tick();
    fu_ready = 1'b1;
    tick();
    fu_ready = 1'b0;
    repeat (done_wait) tick();
    fu_done = 1'b1; fu_result = res;
    tick();
    fu_done = 1'b0;
    repeat (grant_wait) tick();
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  int fin_cnt;
  int req_cnt;

  initial begin
    load_rs();
    reset = 1'b1; flush = 1'b0;
    fu_ready = 1'b0; fu_done = 1'b0; cdb_grant = 1'b0; fu_result = '0;
    @(posedge clk);
    #1;
    model_on = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    chk("reset_finish", finish, 0);
    chk("reset_fu_valid", fu_valid, 0);
    chk("reset_cdb_req", cdb_req, 0);
    chk("reset_cdb_out", cdb_out, 0);
    chk("reset_busy", busy, 0);
    tick();

    // single eligible entry: same-cycle finish, operands next cycle
    make_eligible(2);
    #2;
    chk("t1_finish", finish, 1);
    chk("t1_index", finish_index, 2);
    tick();
    #2;
    chk("t1_fu_valid", fu_valid, 1);
    chk("t1_fu_a", fu_a, 16'h1002);
    chk("t1_fu_b", fu_b, 16'h2002);
    complete_op(0, 0, 0, 16'h4242);

    // round-robin order with back-to-back completions
    do_reset();
    load_rs();
    for (int i = 0; i < 4; i++) make_eligible(i);
    exp_q = {};
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    for (int n = 0; n < 5; n++) begin
      if (n == 4) begin
        make_eligible(0);
        make_eligible(1);
      end
      #2;
      chk("t2_finish", finish, 1);
      chk("t2_order", finish_index, exp_q.pop_front());
      tick();
      complete_op(0, 0, 0, 16'h5000 + 16'(n));
    end

    // FU back-pressure: operands held, no second finish
    do_reset();
    load_rs();
    make_eligible(1);
    #2;
    chk("t3_index", finish_index, 1);
    tick();
    make_eligible(3);
    fin_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      #2;
      chk("t3_fu_valid", fu_valid, 1);
      chk("t3_fu_a", fu_a, 16'h1001);
      chk("t3_fu_b", fu_b, 16'h2001);
      if (finish) fin_cnt++;
      tick();
    end
    chk("t3_no_refinish", fin_cnt, 0);
    complete_op(0, 0, 0, 16'h6000);

    // delayed grant: request held, ready only in the grant cycle
    do_reset();
    load_rs();
    e_dest[0] = 3'd5;
    make_eligible(0);
    #2;
    chk("t4_index", finish_index, 0);
    tick();
    fu_ready = 1'b1;
    tick();
    fu_ready = 1'b0;
    fu_done = 1'b1; fu_result = 16'h1234;
    tick();
    fu_done = 1'b0;
    req_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("t4_cdb_wait", cdb_out, {3'd5, 16'h1234, 1'b0});
      if (cdb_req) req_cnt++;
      tick();
    end
    cdb_grant = 1'b1;
    #2;
    chk("t4_cdb_grant", cdb_out, {3'd5, 16'h1234, 1'b1});
    if (cdb_req) req_cnt++;
    tick();
    cdb_grant = 1'b0;
    #2;
    chk("t4_req_cycles", req_cnt, 4);
    chk("t4_req_drop", cdb_req, 0);
    tick();

    // flush collides with grant in BCAST
    do_reset();
    load_rs();
    make_eligible(2);
    #2;
    chk("t5_index", finish_index, 2);
    tick();
    fu_ready = 1'b1;
    tick();
    fu_ready = 1'b0;
    fu_done = 1'b1; fu_result = 16'hBEEF;
    tick();
    fu_done = 1'b0;
    cdb_grant = 1'b1;
    flush = 1'b1;
    #2;
    chk("t5_cdb_ready", cdb_out[0], 0);
    chk("t5_cdb_req", cdb_req, 0);
    tick();
    cdb_grant = 1'b0;
    flush = 1'b0;
    #2;
    chk("t5_busy", busy, 0);
    chk("t5_state", dbg_state, 0);
    tick();
    #2;
    chk("t5_no_bcast", cdb_req, 0);
    tick();

    // reset in EXEC, late fu_done ignored, pointer back to 0
    do_reset();
    load_rs();
    make_eligible(0);
    #2;
    chk("t6_index", finish_index, 0);
    tick();
    fu_ready = 1'b1;
    tick();
    fu_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fu_done = 1'b1; fu_result = 16'hDEAD;
    tick();
    fu_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("t6_no_req", cdb_req, 0);
      chk("t6_idle", busy, 0);
      tick();
    end
    make_eligible(0);
    make_eligible(1);
    #2;
    chk("t6_finish", finish, 1);
    chk("t6_rr_zero", finish_index, 0);
    tick();
    complete_op(1, 1, 1, 16'h7777);
    tick();

    model_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
